// File: rtl/broken_array_multiplier_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : broken_array_multiplier_seq_if
// Description : Operand/result handshake bundle for the sequential BAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface broken_array_multiplier_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WIDTH-1:0]     multiplicand_i;
    logic [WIDTH-1:0]     multiplier_i;
    logic                 approx_en_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [2*WIDTH-1:0]   product_o;
    logic                 busy_o;

    modport slave (
        input  in_valid_i, multiplicand_i, multiplier_i, approx_en_i, out_ready_i,
        output in_ready_o, out_valid_o, product_o, busy_o
    );

    modport master (
        output in_valid_i, multiplicand_i, multiplier_i, approx_en_i, out_ready_i,
        input  in_ready_o, out_valid_o, product_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/broken_array_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : broken_array_multiplier_seq
// Description : Sequential unsigned broken-array multiplier, one row per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module broken_array_multiplier_seq #(
    parameter int WIDTH = 8,
    parameter int HBL   = 2,
    parameter int VBL   = 8
) (
    input  wire                           clk_i,
    input  wire                           rst_n_i,
    broken_array_multiplier_seq_if.slave  bus
);
    localparam int ROW_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [ROW_W-1:0]    row_q,       row_d;
    logic [WIDTH-1:0]    a_q,         a_d;
    logic [WIDTH-1:0]    b_q,         b_d;
    logic                approx_q,    approx_d;
    logic [PROD_W-1:0]   acc_q,       acc_d;
    logic [PROD_W-1:0]   product_q,   product_d;
    logic                in_ready_q,  in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q,      busy_d;

    logic [WIDTH-1:0]    row_mask;
    logic [PROD_W-1:0]   row_term;
    logic                last_row;

    // Kept cells of the current row; broken cells contribute nothing but still cost a cycle.
    always_comb begin
        row_mask = '0;
        for (int j = 0; j < WIDTH; j++) begin
            row_mask[j] = !approx_q ||
                          ((int'(row_q) >= HBL) && ((int'(row_q) + j) >= VBL));
        end
        row_term = '0;
        if (b_q[row_q]) begin
            row_term = PROD_W'(a_q & row_mask) << row_q;
        end
    end

    assign last_row = (row_q == ROW_W'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        a_d         = a_q;
        b_d         = b_q;
        approx_d    = approx_q;
        acc_d       = acc_q;
        product_d   = product_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid_i && in_ready_q) begin
                    a_d        = bus.multiplicand_i;
                    b_d        = bus.multiplier_i;
                    approx_d   = bus.approx_en_i;
                    acc_d      = '0;
                    row_d      = '0;
                    state_d    = ST_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_RUN: begin
                acc_d = acc_q + row_term;
                if (last_row) begin
                    state_d     = ST_DONE;
                    product_d   = acc_q + row_term;
                    out_valid_d = 1'b1;
                    row_d       = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            ST_DONE: begin
                // Returning to IDLE first means a new operand is never taken on the output handshake edge.
                if (bus.out_ready_i) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                row_d       = '0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            approx_q    <= 1'b0;
            acc_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            a_q         <= a_d;
            b_q         <= b_d;
            approx_q    <= approx_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.product_o   = product_q;
    assign bus.busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_broken_array_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_broken_array_multiplier_seq
// Description : Self-checking bench for the sequential BAM against a mask-sum model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_broken_array_multiplier_seq;
    localparam int W = 8;
    localparam int H = 2;
    localparam int V = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic aux_en = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   aux_cnt[2];
    int   aux_pending[2];

    always #5 clk = ~clk;

    broken_array_multiplier_seq_if #(.WIDTH(W)) m ();
    broken_array_multiplier_seq #(.WIDTH(W), .HBL(H), .VBL(V)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (m)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Sum of a_j*b_i*2^(i+j) over every cell the break levels keep.
    function automatic logic [63:0] ref_bam(input logic [63:0] a, input logic [63:0] b,
                                            input logic ap, input int w, input int h, input int v);
        logic [63:0] s;
        s = 64'd0;
        for (int i = 0; i < w; i++)
            for (int j = 0; j < w; j++)
                if (a[j] && b[i] && (!ap || (i >= h && i + j >= v)))
                    s += (64'd1 << (i + j));
        return s;
    endfunction

    // Secondary configurations: exact-by-parameter (HBL=VBL=0) and a narrow WIDTH=4 array.
    for (genvar k = 0; k < 2; k++) begin : g_aux
        localparam int AW = (k == 0) ? 8 : 4;
        localparam int AH = (k == 0) ? 0 : 1;
        localparam int AV = (k == 0) ? 0 : 3;
        logic [63:0] q[$];

        broken_array_multiplier_seq_if #(.WIDTH(AW)) ax ();
        broken_array_multiplier_seq #(.WIDTH(AW), .HBL(AH), .VBL(AV)) u_aux (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .bus     (ax)
        );

        initial begin
            ax.in_valid_i     = 1'b0;
            ax.multiplicand_i = '0;
            ax.multiplier_i   = '0;
            ax.approx_en_i    = 1'b0;
            ax.out_ready_i    = 1'b1;
            aux_cnt[k]        = 0;
            aux_pending[k]    = 0;
        end

        always @(negedge clk) begin
            if (aux_en) begin
                ax.in_valid_i     = 1'($urandom_range(0, 1));
                ax.multiplicand_i = AW'($urandom);
                ax.multiplier_i   = AW'($urandom);
                ax.approx_en_i    = 1'($urandom_range(0, 1));
                ax.out_ready_i    = ($urandom_range(0, 3) != 0);
            end else begin
                ax.in_valid_i  = 1'b0;
                ax.out_ready_i = 1'b1;
            end
            if (ax.in_valid_i && ax.in_ready_o)
                q.push_back(ref_bam(64'(ax.multiplicand_i), 64'(ax.multiplier_i),
                                    ax.approx_en_i, AW, AH, AV));
            if (ax.out_valid_o && ax.out_ready_i) begin
                if (q.size() == 0) check("aux_spurious_result", 1, 0);
                else check("aux_product", 64'(ax.product_o), q.pop_front());
                aux_cnt[k]++;
            end
            aux_pending[k] = q.size();
        end
    end

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!m.out_valid_o && lat < 50) begin
            @(negedge clk);
            lat++;
            if (lat == 2) m.in_valid_i = 1'b1;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap, input int hold);
        int lat;
        logic [63:0] exp;
        exp = ref_bam(64'(a), 64'(b), ap, W, H, V);
        @(negedge clk);
        m.in_valid_i     = 1'b1;
        m.multiplicand_i = a;
        m.multiplier_i   = b;
        m.approx_en_i    = ap;
        m.out_ready_i    = 1'b0;
        check("idle_in_ready", 64'(m.in_ready_o), 1);
        @(negedge clk);
        m.in_valid_i     = 1'b0;
        m.multiplicand_i = W'($urandom);
        m.multiplier_i   = W'($urandom);
        m.approx_en_i    = 1'($urandom_range(0, 1));
        check("run_in_ready", 64'(m.in_ready_o), 0);
        check("run_busy", 64'(m.busy_o), 1);
        wait_valid(lat);
        check("latency", 64'(lat), W);
        check("product", 64'(m.product_o), exp);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 64'(m.out_valid_o), 1);
            check("hold_product", 64'(m.product_o), exp);
            check("hold_in_ready", 64'(m.in_ready_o), 0);
        end
        m.out_ready_i = 1'b1;
        @(negedge clk);
        m.in_valid_i  = 1'b0;
        m.out_ready_i = 1'b0;
        check("post_valid", 64'(m.out_valid_o), 0);
        check("post_in_ready", 64'(m.in_ready_o), 1);
        check("post_busy", 64'(m.busy_o), 0);
    endtask

    initial begin
        int lat;
        logic [63:0] e1, e2;
        m.in_valid_i     = 1'b0;
        m.multiplicand_i = '0;
        m.multiplier_i   = '0;
        m.approx_en_i    = 1'b0;
        m.out_ready_i    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(m.in_ready_o), 1);
        check("rst_out_valid", 64'(m.out_valid_o), 0);
        check("rst_busy", 64'(m.busy_o), 0);
        check("rst_product", 64'(m.product_o), 0);
        rst_n = 1'b1;

        run_op(8'd255, 8'd255, 1'b0, 0);
        check("exact_ref", ref_bam(255, 255, 1'b0, W, H, V), 65025);
        run_op(8'd255, 8'd255, 1'b1, 0);
        check("approx_ref", ref_bam(255, 255, 1'b1, W, H, V), 62976);
        run_op(8'd1,   8'd1,   1'b1, 0);
        run_op(8'd0,   8'd200, 1'b1, 0);
        run_op(8'd0,   8'd200, 1'b0, 0);
        run_op(8'hA5,  8'h3C,  1'b1, 5);

        // Back-to-back with out_ready held high; second operands wait on in_valid throughout.
        e1 = ref_bam(64'd200, 64'd77, 1'b0, W, H, V);
        e2 = ref_bam(64'd123, 64'd231, 1'b1, W, H, V);
        @(negedge clk);
        m.out_ready_i = 1'b1;
        m.in_valid_i = 1'b1; m.multiplicand_i = 8'd200; m.multiplier_i = 8'd77; m.approx_en_i = 1'b0;
        @(negedge clk);
        m.multiplicand_i = 8'd123; m.multiplier_i = 8'd231; m.approx_en_i = 1'b1;
        wait_valid(lat);
        check("b2b_latency1", 64'(lat), W);
        check("b2b_product1", 64'(m.product_o), e1);
        @(negedge clk);
        check("b2b_gap_in_ready", 64'(m.in_ready_o), 1);
        check("b2b_gap_valid", 64'(m.out_valid_o), 0);
        @(negedge clk);
        check("b2b_second_accept", 64'(m.in_ready_o), 0);
        m.in_valid_i = 1'b0;
        wait_valid(lat);
        check("b2b_latency2", 64'(lat), W);
        check("b2b_product2", 64'(m.product_o), e2);
        @(negedge clk);
        m.in_valid_i  = 1'b0;
        m.out_ready_i = 1'b0;
        check("b2b_end_in_ready", 64'(m.in_ready_o), 1);

        // Reset while row 3 is pending.
        @(negedge clk);
        m.in_valid_i = 1'b1; m.multiplicand_i = 8'd99; m.multiplier_i = 8'd255; m.approx_en_i = 1'b0;
        @(negedge clk);
        m.in_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(m.in_ready_o), 1);
        check("midrst_out_valid", 64'(m.out_valid_o), 0);
        check("midrst_busy", 64'(m.busy_o), 0);
        check("midrst_product", 64'(m.product_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd17, 8'd240, 1'b1, 1);

        aux_en = 1'b1;
        for (int n = 0; n < 1500; n++)
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        aux_en = 1'b0;
        repeat (30) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("aux_results_seen", 64'(aux_cnt[k] > 0), 1);
            check("aux_drained", 64'(aux_pending[k]), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
